// File: rtl/add16_arbiter_pkg.sv
// add16_arb_pkg: state encoding, default width and ID-width helper for add16_arbiter.
package add16_arb_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_RESP = 2'd2} state_t;
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/add16_arbiter_if.sv
// add16_arbiter_if: request, shared-adder and response signals of add16_arbiter.
interface add16_arbiter_if
  import add16_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int ID_W = id_width(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_out;
  logic rsp_valid;
  logic rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic [ID_W-1:0] rsp_id;
  modport slave (
    input req_valid, req_a, req_b, add_out, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_out, rsp_id
  );
  modport master (
    output req_valid, req_a, req_b, add_out, rsp_ready,
    input req_ready, add_a, add_b, rsp_valid, rsp_out, rsp_id
  );
endinterface

// File: rtl/add16_arbiter_rr_pick.sv
// add16_rr_pick: round-robin winner search from ptr+1; fixed lowest-index priority
// when ADD16_ARB_FIXED_PRI_EN is defined.
module add16_rr_pick
  import add16_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  logic [ID_W-1:0] j;
  // Scanning from the far end down lets the nearest candidate overwrite the others.
  always_comb begin
    idx = '0;
    j = '0;
`ifdef ADD16_ARB_FIXED_PRI_EN
    for (int k = N - 1; k >= 0; k--) begin
      j = ID_W'(k);
      if (req[j]) idx = j;
    end
`else
    for (int k = N; k >= 1; k--) begin
      j = ID_W'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
`endif
  end
  assign any = |req;
  assign grant = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/add16_arbiter.sv
// add16_arbiter: shares one external adder among NUM_REQ requesters via an IDLE/CALC/RESP FSM.
// Define ADD16_ARB_FIXED_PRI_EN for fixed priority instead of round-robin.
module add16_arbiter
  import add16_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic reset,
  add16_arbiter_if.slave bus
);
  localparam int ID_W = id_width(NUM_REQ);
  state_t state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] idx;
  logic [NUM_REQ-1:0] grant;
  logic any;
  logic [NUM_REQ-1:0][WIDTH-1:0] a_arr;
  logic [NUM_REQ-1:0][WIDTH-1:0] b_arr;
  assign a_arr = bus.req_a;
  assign b_arr = bus.req_b;
  add16_rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req(bus.req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
  assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= ID_W'(NUM_REQ - 1);
      id <= '0;
      bus.add_a <= '0;
      bus.add_b <= '0;
      bus.rsp_out <= '0;
      bus.rsp_id <= '0;
      bus.rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any) begin
          bus.add_a <= a_arr[idx];
          bus.add_b <= b_arr[idx];
          id <= idx;
          ptr <= idx;
          state <= ST_CALC;
        end
        ST_CALC: begin
          bus.rsp_out <= bus.add_out;
          bus.rsp_id <= id;
          bus.rsp_valid <= 1'b1;
          state <= ST_RESP;
        end
        ST_RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add16_arbiter.sv
// tb_add16_arbiter: directed self-checking bench for add16_arbiter with a behavioural adder.
module tb_add16_arbiter;
  import add16_arb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  add16_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) bus ();
  add16_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.add_out = bus.add_a + bus.add_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    set_req(i, a, b);
    bus.req_valid = 4'(1 << i);
    bus.rsp_ready = 1'b1;
    #1;
    chk("op_grant", 32'(bus.req_ready), 32'(1 << i));
    tick();
    bus.req_valid = '0;
    chk("op_calc_ready", 32'(bus.req_ready), 0);
    chk("op_calc_valid", 32'(bus.rsp_valid), 0);
    tick();
    chk("op_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("op_rsp_out", 32'(bus.rsp_out), 32'(exp));
    chk("op_rsp_id", 32'(bus.rsp_id), 32'(i));
    tick();
    chk("op_release", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    int order [5];
    logic [15:0] sums [4];
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("reset_async_valid", 32'(bus.rsp_valid), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_state", 32'(dut.state), 32'(ST_IDLE));
    chk("idle_ready", 32'(bus.req_ready), 0);
    chk("idle_valid", 32'(bus.rsp_valid), 0);
    chk("idle_add_a", 32'(bus.add_a), 0);
    chk("idle_add_b", 32'(bus.add_b), 0);
    chk("idle_rsp_out", 32'(bus.rsp_out), 0);
    chk("idle_rsp_id", 32'(bus.rsp_id), 0);

    // single request on requester 0
    set_req(0, 16'h1234, 16'h9876);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("single_ready_pulse", 32'(bus.req_ready), 0);
    chk("single_add_a", 32'(bus.add_a), 32'h1234);
    chk("single_add_b", 32'(bus.add_b), 32'h9876);
    chk("single_no_rsp_yet", 32'(bus.rsp_valid), 0);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("single_rsp_out", 32'(bus.rsp_out), 32'hAAAA);
    chk("single_rsp_id", 32'(bus.rsp_id), 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("single_done", 32'(bus.rsp_valid), 0);

    do_op(2, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    do_op(2, 16'hAAAA, 16'h5555, 16'hFFFF);
    do_op(3, 16'h0001, 16'h0002, 16'h0003);

    // all requesters valid with free-flowing responses
    set_req(0, 16'h1000, 16'h0011);
    set_req(1, 16'h2000, 16'h0022);
    set_req(2, 16'h3000, 16'h0033);
    set_req(3, 16'h4000, 16'h0044);
    sums = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};
`ifdef ADD16_ARB_FIXED_PRI_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("all_grant", 32'(bus.req_ready), 32'(1 << order[n]));
      tick();
      tick();
      chk("all_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("all_rsp_id", 32'(bus.rsp_id), 32'(order[n]));
      chk("all_rsp_out", 32'(bus.rsp_out), 32'(sums[order[n]]));
      tick();
    end
    bus.req_valid = '0;
    tick();

    // backpressure in RESP
    bus.rsp_ready = 1'b0;
    set_req(1, 16'h0100, 16'h0023);
    bus.req_valid = 4'b0010;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1111;
    tick();
    for (int n = 0; n < 6; n++) begin
      chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_out", 32'(bus.rsp_out), 32'h0123);
      chk("bp_hold_id", 32'(bus.rsp_id), 1);
      chk("bp_no_grant", 32'(bus.req_ready), 0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.rsp_valid), 0);
    chk("bp_release_state", 32'(dut.state), 32'(ST_IDLE));
    tick();

    // asynchronous reset while an op is in CALC
    set_req(1, 16'h0F0F, 16'h00F0);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    chk("rst_in_calc", 32'(dut.state), 32'(ST_CALC));
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_add_a", 32'(bus.add_a), 0);
    chk("rst_add_b", 32'(bus.add_b), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_out", 32'(bus.rsp_out), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_no_stale", 32'(bus.rsp_valid), 0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_first_winner", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
